// File: rtl/apb3_uart_rx.sv
// APB3 responder that receives 8N1 UART frames, buffers bytes in a small FIFO
// and exposes data, status, divisor and interrupt-enable registers.
module apb3_uart_rx #(
    parameter int FIFO_DEPTH      = 8,
    parameter int DEFAULT_DIV     = 434,
    parameter int APB3_ADDR_WIDTH = 32,
    parameter int APB3_DATA_WIDTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [APB3_ADDR_WIDTH-1:0] paddr,
    input  logic [APB3_DATA_WIDTH-1:0] pwdata,
    output logic [APB3_DATA_WIDTH-1:0] prdata,
    output logic                       pready,
    output logic                       pslverr,
    input  logic                       i_uart_rx,
    output logic                       o_irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } rx_state_e;

    logic             rx_meta_q, rx_meta_d;
    logic             rx_sync_q, rx_sync_d;
    rx_state_e        state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [15:0]      div_q, div_d;
    logic [1:0]       irq_en_q, irq_en_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_q, irq_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic access, addr_ok, rd_en, wr_en;
    logic not_empty, full, pop;
    logic push_req, push_do, overrun_set, frame_err_set;
    logic wr_status;
    logic [APB3_DATA_WIDTH-1:0] rdata;
    logic unused_bits;

    assign access    = psel & penable;
    assign addr_ok   = (paddr[11:4] == 8'h00);
    assign rd_en     = access & ~pwrite & addr_ok;
    assign wr_en     = access & pwrite & addr_ok;
    assign wr_status = wr_en & (paddr[3:0] == 4'h4);

    assign not_empty = (count_q != '0);
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = rd_en & (paddr[3:0] == 4'h0) & not_empty;

    // A full FIFO can still accept the byte when software frees a slot on the same edge.
    assign push_do     = push_req & (~full | pop);
    assign overrun_set = push_req & full & ~pop;

    assign unused_bits = ^{paddr[APB3_ADDR_WIDTH-1:12], pwdata[APB3_DATA_WIDTH-1:16]};

    // Receive FSM: one down-counter times both the half-bit to the start sample and each full bit.
    always_comb begin
        // NOTE: every _d signal gets a default first so no path leaves it unassigned and infers a latch.
        rx_meta_d     = i_uart_rx;
        rx_sync_d     = rx_meta_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        push_req      = 1'b0;
        frame_err_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_sync_q) begin
                    cnt_d   = (div_q >> 1) - 16'd1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (!rx_sync_q) begin
                        bit_idx_d = '0;
                        cnt_d     = div_q - 16'd1;
                        state_d   = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d[bit_idx_q] = rx_sync_q;
                    cnt_d              = div_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (rx_sync_q) begin
                        push_req = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        frame_err_set = 1'b1;
                        state_d       = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        div_d       = div_q;
        irq_en_d    = irq_en_q;
        overrun_d   = (overrun_q & ~(wr_status & pwdata[2])) | overrun_set;
        frame_err_d = (frame_err_q & ~(wr_status & pwdata[3])) | frame_err_set;
        irq_d       = (irq_en_q[0] & not_empty) | (irq_en_q[1] & (overrun_q | frame_err_q));
        if (push_do) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_do, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (wr_en && paddr[3:0] == 4'h8) begin
            div_d = (pwdata[15:0] < 16'd4) ? 16'd4 : pwdata[15:0];
        end
        if (wr_en && paddr[3:0] == 4'hC) begin
            irq_en_d = pwdata[1:0];
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (paddr[3:0])
                4'h0: begin
                    rdata[8] = not_empty;
                    if (not_empty) begin
                        rdata[7:0] = mem_q[rd_ptr_q];
                    end
                end
                4'h4: begin
                    rdata[0]           = not_empty;
                    rdata[1]           = full;
                    rdata[2]           = overrun_q;
                    rdata[3]           = frame_err_q;
                    rdata[4 +: CNT_W]  = count_q;
                end
                4'h8:    rdata[15:0] = div_q;
                4'hC:    rdata[1:0]  = irq_en_q;
                default: rdata       = '0;
            endcase
        end
    end

    assign prdata  = rdata;
    assign pslverr = access & ~addr_ok;
    assign pready  = 1'b1;
    assign o_irq   = irq_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            div_q       <= 16'(DEFAULT_DIV);
            irq_en_q    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            div_q       <= div_d;
            irq_en_q    <= irq_en_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            irq_q       <= irq_d;
        end
    end

    // NOTE: the storage array has no reset; count and pointers define validity, so it can map to RAM.
    always_ff @(posedge i_clk) begin
        if (push_do) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

endmodule

// File: tb/tb_apb3_uart_rx.sv
// Directed bench for apb3_uart_rx: serial frames in, APB reads out, with a
// byte scoreboard filled when frames are sent and drained on DATA reads.
module tb_apb3_uart_rx;

    localparam logic [31:0] A_DATA   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_DIV    = 32'h8;
    localparam logic [31:0] A_IRQEN  = 32'hC;
    localparam logic [31:0] A_BAD    = 32'h10;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic        i_uart_rx;
    logic        o_irq;

    int         n_checks = 0;
    int         n_errors = 0;
    int         div;
    int         irq_rise;
    logic [7:0] sb [$];
    logic [31:0] rd;
    logic        err;

    apb3_uart_rx #(
        .FIFO_DEPTH     (8),
        .DEFAULT_DIV    (434),
        .APB3_ADDR_WIDTH(32),
        .APB3_DATA_WIDTH(32)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .i_uart_rx(i_uart_rx),
        .o_irq    (o_irq)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Each APB task starts and ends on a falling edge; the access completes on the rising edge between.
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic slverr);
        @(negedge i_clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(negedge i_clk);
        penable = 1'b1;
        #1 slverr = pslverr;
        @(negedge i_clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic slverr);
        @(negedge i_clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(negedge i_clk);
        penable = 1'b1;
        #1;
        data   = prdata;
        slverr = pslverr;
        @(negedge i_clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_read(addr, d, e);
        check(tag, d, exp);
    endtask

    task automatic check_data(input string tag);
        logic [31:0] d;
        logic [31:0] exp;
        logic        e;
        apb_read(A_DATA, d, e);
        exp = '0;
        if (sb.size() > 0) exp = {23'd0, 1'b1, sb.pop_front()};
        check(tag, d, exp);
    endtask

    // 8N1 frame, LSB first, each bit held for div clocks; must be called on a falling edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        i_uart_rx = 1'b0;
        repeat (div) @(negedge i_clk);
        for (int i = 0; i < 8; i++) begin
            i_uart_rx = b[i];
            repeat (div) @(negedge i_clk);
        end
        i_uart_rx = stop_bit;
        repeat (div) @(negedge i_clk);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; i_uart_rx = 1'b1; div = 434;
        repeat (3) @(negedge i_clk);
        check("rst_prdata", prdata, 32'h0);
        check("rst_pready", {31'd0, pready}, 32'h1);
        check("rst_pslverr", {31'd0, pslverr}, 32'h0);
        check("rst_irq", {31'd0, o_irq}, 32'h0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        read_check("rst_status", A_STATUS, 32'h0);
        read_check("rst_div", A_DIV, 32'd434);
        read_check("rst_irqen", A_IRQEN, 32'h0);

        // Single byte at DIV = 8
        apb_write(A_DIV, 32'd8, err);
        div = 8;
        read_check("div8", A_DIV, 32'd8);
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        repeat (div) @(negedge i_clk);
        read_check("a5_status", A_STATUS, 32'h011);
        check_data("a5_data");
        read_check("a5_status_after", A_STATUS, 32'h000);

        // Nine bytes into an eight-entry FIFO: the ninth overruns
        for (int b = 1; b <= 9; b++) begin
            if (b <= 8) sb.push_back(8'(b));
            send_frame(8'(b), 1'b1);
        end
        repeat (div) @(negedge i_clk);
        read_check("ovr_status", A_STATUS, 32'h087);
        for (int i = 0; i < 8; i++) check_data($sformatf("ovr_data%0d", i));
        check_data("ovr_data_empty");
        apb_write(A_STATUS, 32'h4, err);
        read_check("ovr_cleared", A_STATUS, 32'h000);

        // Frame error followed by a long break, then a good byte
        send_frame(8'h3C, 1'b0);
        repeat (20 * div) @(negedge i_clk);
        read_check("fe_status", A_STATUS, 32'h008);
        i_uart_rx = 1'b1;
        repeat (2 * div) @(negedge i_clk);
        sb.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        repeat (div) @(negedge i_clk);
        check_data("fe_next_data");
        read_check("fe_sticky", A_STATUS, 32'h008);
        apb_write(A_STATUS, 32'h8, err);
        read_check("fe_cleared", A_STATUS, 32'h000);

        // Two-clock glitch must not start a frame; DIV floor of 4
        i_uart_rx = 1'b0;
        repeat (2) @(negedge i_clk);
        i_uart_rx = 1'b1;
        repeat (4 * div) @(negedge i_clk);
        read_check("glitch_status", A_STATUS, 32'h000);
        check_data("glitch_data");
        apb_write(A_DIV, 32'd2, err);
        read_check("div_floor", A_DIV, 32'd4);
        apb_write(A_DIV, 32'd8, err);

        // Not-empty interrupt: expected rise is on the edge after the stop sample.
        // First edge after the fall is edge 1; start sample at edge 3+div/2, stop sample 9*div later.
        apb_write(A_IRQEN, 32'h1, err);
        sb.push_back(8'h5A);
        irq_rise = -1;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge i_clk);
                    if (o_irq && irq_rise < 0) irq_rise = i;
                end
            end
        join
        check("irq_rise_cycle", irq_rise, 3 + div / 2 + 9 * div);
        check_data("irq_data");
        check("irq_hold", {31'd0, o_irq}, 32'h1);
        @(negedge i_clk);
        check("irq_fall", {31'd0, o_irq}, 32'h0);

        // Error interrupt stays up until the flag is cleared
        apb_write(A_IRQEN, 32'h2, err);
        send_frame(8'hC3, 1'b0);
        repeat (2 * div) @(negedge i_clk);
        i_uart_rx = 1'b1;
        repeat (div) @(negedge i_clk);
        check("irq_err_high", {31'd0, o_irq}, 32'h1);
        repeat (50) @(negedge i_clk);
        check("irq_err_still", {31'd0, o_irq}, 32'h1);
        apb_write(A_STATUS, 32'h8, err);
        check("irq_err_lag", {31'd0, o_irq}, 32'h1);
        @(negedge i_clk);
        check("irq_err_clear", {31'd0, o_irq}, 32'h0);

        // Out-of-range address
        apb_write(A_BAD, 32'h3, err);
        check("bad_wr_slverr", {31'd0, err}, 32'h1);
        apb_read(A_BAD, rd, err);
        check("bad_rd_slverr", {31'd0, err}, 32'h1);
        check("bad_rd_data", rd, 32'h0);
        apb_read(A_DIV, rd, err);
        check("bad_div_kept", rd, 32'd8);
        check("good_slverr", {31'd0, err}, 32'h0);
        read_check("bad_irqen_kept", A_IRQEN, 32'h2);

        // Reset in the middle of a frame with a byte already buffered
        apb_write(A_IRQEN, 32'h1, err);
        send_frame(8'h11, 1'b1);
        repeat (div) @(negedge i_clk);
        check("pre_rst_irq", {31'd0, o_irq}, 32'h1);
        i_uart_rx = 1'b0;
        repeat (div) @(negedge i_clk);
        i_uart_rx = 1'b1;
        repeat (2 * div) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_irq", {31'd0, o_irq}, 32'h0);
        check("mid_rst_prdata", prdata, 32'h0);
        check("mid_rst_pready", {31'd0, pready}, 32'h1);
        check("mid_rst_pslverr", {31'd0, pslverr}, 32'h0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        div = 434;
        repeat (2) @(negedge i_clk);
        read_check("post_rst_status", A_STATUS, 32'h000);
        read_check("post_rst_div", A_DIV, 32'd434);
        read_check("post_rst_irqen", A_IRQEN, 32'h0);
        apb_write(A_DIV, 32'd8, err);
        div = 8;
        sb.delete();
        sb.push_back(8'h96);
        send_frame(8'h96, 1'b1);
        repeat (div) @(negedge i_clk);
        check_data("post_rst_data");
        read_check("post_rst_status2", A_STATUS, 32'h000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
